ima_adpcm_blk_unpack: RTL

- Upstream feeder for the IMA ADPCM decoder.
- Accepts a byte stream of fixed-size ADPCM blocks. Each block is a 4-byte header followed by packed data bytes.
- Parses the header into a decoder state load, then unpacks each data byte into two 4-bit codes.
- Issues the codes to the decoder's inPCM/inValid/inReady interface.

---
 rtl/ima_adpcm_blk_unpack.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ima_adpcm_blk_unpack.sv
// ----------------------------------------------------------------------------
// ima_adpcm_blk_unpack
//   Upstream feeder for an IMA ADPCM decoder. Takes a byte stream of
//   fixed-size blocks (4-byte header + packed data bytes), loads the header
//   into the decoder state and issues each data byte as two 4-bit codes.
//
// Parameters
//   BLOCK_BYTES : total bytes per block including the header (5..65535)
//   CNT_W       : byte counter width, must hold BLOCK_BYTES-1
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   inByte         input stream byte
//   inByteValid    inByte is valid
//   inByteReady    byte taken on inByteValid && inByteReady
//   outPCM         ADPCM code to the decoder
//   outValid       outPCM is valid
//   outReady       decoder ready
//   outPredictSamp header predictor sample
//   outStepIndex   header step index, clamped to 0..88
//   outStateLoad   one-cycle decoder state load pulse
//   hdrError       one-cycle pulse: header step index was above 88
//   blkDone        one-cycle pulse: last code of a block transferred
//
// Build option
//   ADPCM_UNPACK_HIGH_NIBBLE_FIRST_EN : issue bits 7:4 before bits 3:0.
//   Default (undefined) is IMA/WAV order, low nibble first.
// ----------------------------------------------------------------------------
module ima_adpcm_blk_unpack #(
  parameter int unsigned BLOCK_BYTES = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  inByte,
  input  logic        inByteValid,
  output logic        inByteReady,
  output logic [3:0]  outPCM,
  output logic        outValid,
  input  logic        outReady,
  output logic [15:0] outPredictSamp,
  output logic [6:0]  outStepIndex,
  output logic        outStateLoad,
  output logic        hdrError,
  output logic        blkDone
);

  typedef enum logic [2:0] {HDR0, HDR1, HDR2, HDR3, LOAD, GAP, DATA} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BYTES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       hold;
  logic             full;       // holding register has a byte
  logic             nib;        // 0: first code of the byte pending, 1: second
  logic             last;       // holding register carries the block's final byte
  logic             live;       // first clock since reset release has happened
  logic             hdr_state;
  logic             byte_acc;
  logic             code_xfer;
  logic             blk_end;

  assign hdr_state   = (state == HDR0) || (state == HDR1) ||
                       (state == HDR2) || (state == HDR3);
  // live keeps inByteReady low while reset is held even though HDR0 is active.
  assign inByteReady = live && (hdr_state || ((state == DATA) && !full));
  assign outValid    = (state == DATA) && full;
  assign byte_acc    = inByteValid && inByteReady;
  assign code_xfer   = outValid && outReady;
  assign blk_end     = code_xfer && nib && last;

`ifdef ADPCM_UNPACK_HIGH_NIBBLE_FIRST_EN
  assign outPCM = nib ? hold[3:0] : hold[7:4];
`else
  assign outPCM = nib ? hold[7:4] : hold[3:0];
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= HDR0;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave it unassigned and infer a latch.
    state_nxt    = state;
    outStateLoad = 1'b0;
    case (state)
      HDR0:    if (byte_acc) state_nxt = HDR1;
      HDR1:    if (byte_acc) state_nxt = HDR2;
      HDR2:    if (byte_acc) state_nxt = HDR3;
      HDR3:    if (byte_acc) state_nxt = LOAD;
      LOAD: begin
        outStateLoad = 1'b1;
        state_nxt    = GAP;
      end
      GAP:     state_nxt = DATA;   // lets the decoder step table settle
      DATA:    if (blk_end) state_nxt = HDR0;
      default: state_nxt = HDR0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the holding register is reset too, so outPCM reads 0 out of
      // reset rather than whatever the flops powered up with.
      hold           <= '0;
      full           <= 1'b0;
      nib            <= 1'b0;
      last           <= 1'b0;
      live           <= 1'b0;
      cnt            <= '0;
      outPredictSamp <= '0;
      outStepIndex   <= '0;
      hdrError       <= 1'b0;
      blkDone        <= 1'b0;
    end else begin
      live     <= 1'b1;
      hdrError <= 1'b0;
      blkDone  <= 1'b0;

      if (byte_acc) begin
        // The final byte is flagged instead of counted so the counter never
        // needs to represent BLOCK_BYTES itself.
        if (cnt == LAST_IDX) last <= 1'b1;
        else                 cnt  <= cnt + 1'b1;
        case (state)
          HDR0: outPredictSamp[7:0]  <= inByte;
          HDR1: outPredictSamp[15:8] <= inByte;
          HDR2: begin
            if (inByte > 8'd88) begin
              outStepIndex <= 7'd88;
              hdrError     <= 1'b1;
            end else begin
              outStepIndex <= inByte[6:0];
            end
          end
          DATA: begin
            hold <= inByte;
            full <= 1'b1;
            nib  <= 1'b0;
          end
          default: ;
        endcase
      end

      // A byte can only be taken while the register is empty and a code can
      // only leave while it is full, so the two never collide.
      if (code_xfer) begin
        if (!nib) begin
          nib <= 1'b1;
        end else begin
          full <= 1'b0;
          nib  <= 1'b0;
          if (last) begin
            blkDone <= 1'b1;
            last    <= 1'b0;
            cnt     <= '0;
          end
        end
      end
    end
  end

endmodule
